// File: rtl/smem_pkg.sv
// Shared constants, field positions and state encoding for the shared-memory
// requester and any future multi-requester arbiter.
package smem_pkg;

   localparam int NBANKS  = 16;
   localparam int SEL_W   = 4;
   localparam int BANK_AW = 8;
   localparam int DW      = 8;
   localparam int AW      = SEL_W + BANK_AW;
   localparam int SEL_LSB = 0;
   localparam int ROW_LSB = SEL_W;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_t;

   function automatic logic [NBANKS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
      return NBANKS'(1) << sel;
   endfunction

endpackage

// File: rtl/smem_addr_map.sv
// Interleaved address split: low nibble selects the bank, upper byte is the
// row inside that bank, so consecutive addresses walk across banks.
module smem_addr_map
   import smem_pkg::*;
(
   input  logic [AW-1:0]      i_addr,
   output logic [SEL_W-1:0]   o_sel,
   output logic [BANK_AW-1:0] o_row,
   output logic [NBANKS-1:0]  o_onehot
);

   assign o_sel    = i_addr[SEL_LSB +: SEL_W];
   assign o_row    = i_addr[ROW_LSB +: BANK_AW];
   assign o_onehot = sel_onehot(o_sel);

endmodule

// File: rtl/smem_initiator.sv
// Single-outstanding requester: turns one core load/store into a one-cycle
// bank strobe, waits for that bank's finish (or a timeout) and responds.
module smem_initiator
   import smem_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic [11:0]  req_addr,
   input  logic [7:0]   req_wdata,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [7:0]   resp_rdata,
   output logic         resp_err,
   output logic [15:0]  bank_read,
   output logic [15:0]  bank_write,
   output logic [7:0]   bank_addr,
   output logic [7:0]   bank_wdata,
   input  logic [127:0] bank_rdata,
   input  logic [15:0]  bank_finish
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SEL_W-1:0]    r_sel;
   logic                r_write;
   logic [CNT_W-1:0]    r_cnt;
   logic [BANK_AW-1:0]  r_bank_addr;
   logic [DW-1:0]       r_bank_wdata;
   logic [DW-1:0]       r_resp_rdata;
   logic                r_resp_err;
   logic [NBANKS-1:0]   r_bank_read;
   logic [NBANKS-1:0]   r_bank_write;

   logic                w_accept;
   logic                w_fin;
   logic                w_expired;
   logic [SEL_W-1:0]    w_sel;
   logic [BANK_AW-1:0]  w_row;
   logic [NBANKS-1:0]   w_onehot;
   logic [DW-1:0]       w_bank_data;

   smem_addr_map u_map (
      .i_addr   (req_addr),
      .o_sel    (w_sel),
      .o_row    (w_row),
      .o_onehot (w_onehot)
   );

   assign w_accept    = req_valid & req_ready;
   assign w_fin       = bank_finish[r_sel];
   assign w_expired   = (r_cnt == TO_LAST);
   assign w_bank_data = bank_rdata[{r_sel, 3'b000} +: DW];

   always_ff @(posedge clock) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (w_accept) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (w_fin || w_expired) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are registered at the accept edge so they are high for exactly
   // the ISSUE cycle and drop on the following edge without extra logic.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_sel        <= '0;
         r_write      <= 1'b0;
         r_cnt        <= '0;
         r_bank_addr  <= '0;
         r_bank_wdata <= '0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_bank_read  <= '0;
         r_bank_write <= '0;
      end else begin
         r_bank_read  <= '0;
         r_bank_write <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_sel        <= w_sel;
                  r_write      <= req_write;
                  r_bank_addr  <= w_row;
                  r_bank_wdata <= req_wdata;
                  if (req_write) r_bank_write <= w_onehot;
                  else           r_bank_read  <= w_onehot;
               end
            end
            ST_ISSUE: r_cnt <= '0;
            ST_WAIT: begin
               if (w_fin) begin
                  r_resp_rdata <= r_write ? '0 : w_bank_data;
                  r_resp_err   <= 1'b0;
               end else if (w_expired) begin
                  r_resp_rdata <= '0;
                  r_resp_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bank_read  = r_bank_read;
   assign bank_write = r_bank_write;
   assign bank_addr  = r_bank_addr;
   assign bank_wdata = r_bank_wdata;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_smem_initiator.sv
// Scoreboard bench: 16 behavioural banks, a flat-memory reference model, and
// independent monitors for bank strobes and core responses.
module tb_smem_initiator;

   localparam int TO = 15;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_write = 1'b0;
   logic [11:0]  req_addr = '0;
   logic [7:0]   req_wdata = '0;
   logic         resp_valid;
   logic         resp_ready = 1'b1;
   logic [7:0]   resp_rdata;
   logic         resp_err;
   logic [15:0]  bank_read;
   logic [15:0]  bank_write;
   logic [7:0]   bank_addr;
   logic [7:0]   bank_wdata;
   logic [127:0] bank_rdata = '0;
   logic [15:0]  bank_finish = '0;

   smem_initiator #(.TIMEOUT(TO)) dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .bank_read   (bank_read),
      .bank_write  (bank_write),
      .bank_addr   (bank_addr),
      .bank_wdata  (bank_wdata),
      .bank_rdata  (bank_rdata),
      .bank_finish (bank_finish)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] init_val(input logic [11:0] a);
      return 8'((int'(a) * 37) + 11);
   endfunction

   // Bank models: registered finish/data_out one cycle after a strobe.
   logic [7:0] bmem [16][256];
   bit         dead [16];

   initial begin
      for (int i = 0; i < 16; i++)
         for (int r = 0; r < 256; r++)
            bmem[i][r] <= init_val(12'((r * 16) + i));
   end

   always @(posedge clock) begin
      for (int i = 0; i < 16; i++) begin
         bank_finish[i] <= (bank_read[i] | bank_write[i]) & !dead[i];
         if (bank_write[i] && !dead[i]) bmem[i][bank_addr] <= bank_wdata;
         if (bank_read[i] && !dead[i]) bank_rdata[8*i +: 8] <= bmem[i][bank_addr];
      end
   end

   // Reference model: flat address space, one entry per core address.
   logic [7:0] ref_mem [4096];

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         rise;
      bit         exact;
   } resp_t;

   typedef struct {
      int          cyc;
      logic [15:0] rd;
      logic [15:0] wr;
      logic [7:0]  addr;
      logic [7:0]  wdata;
   } iss_t;

   resp_t rq[$];
   iss_t  iq[$];

   bit rand_rdy = 1'b0;
   bit rdy_force = 1'b1;

   always @(posedge clock) begin
      #2;
      resp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   task automatic do_req(input logic w, input logic [11:0] a, input logic [7:0] d,
                         input bit expect_resp);
      int k;
      bit ok;
      resp_t r;
      iss_t s;
      logic [3:0] b;
      ok = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clock);
         if (req_ready) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=no_accept required=accept addr=%0h", a);
         req_valid = 1'b0;
         return;
      end
      k = cyc;
      b = a[3:0];
      s.cyc   = k + 1;
      s.rd    = w ? 16'd0 : (16'd1 << b);
      s.wr    = w ? (16'd1 << b) : 16'd0;
      s.addr  = a[11:4];
      s.wdata = d;
      iq.push_back(s);
      if (dead[b]) begin
         r.rdata = 8'd0;
         r.err   = 1'b1;
         r.rise  = k + 2 + TO;
         r.exact = 1'b0;
      end else begin
         r.err   = 1'b0;
         r.rise  = k + 3;
         r.exact = 1'b1;
         if (w) begin
            ref_mem[a] = d;
            r.rdata = 8'd0;
         end else begin
            r.rdata = ref_mem[a];
         end
      end
      if (expect_resp) rq.push_back(r);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 2000 && (rq.size() != 0 || iq.size() != 0); n++) @(negedge clock);
      @(posedge clock); #1;
   endtask

   // Strobe monitor
   logic [15:0] strb;
   iss_t        s_cur;
   always @(negedge clock) begin
      strb = bank_read | bank_write;
      if (reset && strb != 16'd0) begin
         chk("strobe_onehot", 32'($countones(strb)), 32'd1);
         if (iq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe actual=%0h required=none", strb);
         end else begin
            s_cur = iq.pop_front();
            chk("strobe_cycle", cyc, s_cur.cyc);
            chk("bank_read", 32'(bank_read), 32'(s_cur.rd));
            chk("bank_write", 32'(bank_write), 32'(s_cur.wr));
            chk("bank_addr", 32'(bank_addr), 32'(s_cur.addr));
            chk("bank_wdata", 32'(bank_wdata), 32'(s_cur.wdata));
         end
      end
   end

   // Response monitor
   bit    pv = 1'b0;
   bit    phs = 1'b0;
   resp_t cur;
   always @(negedge clock) begin
      if (!reset) begin
         pv  = 1'b0;
         phs = 1'b0;
      end else begin
         if (phs) chk("resp_valid_drop", 32'(resp_valid), 32'd0);
         if (resp_valid) begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (!pv) begin
               if (rq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp actual=%0h required=none", resp_rdata);
                  cur.rdata = resp_rdata;
                  cur.err   = resp_err;
               end else begin
                  cur = rq.pop_front();
                  if (cur.exact) chk("resp_latency", cyc, cur.rise);
                  else chk("timeout_latency", 32'(cyc >= cur.rise && cyc <= cur.rise + 1), 32'd1);
               end
            end
            chk("resp_rdata", 32'(resp_rdata), 32'(cur.rdata));
            chk("resp_err", 32'(resp_err), 32'(cur.err));
         end
         pv  = resp_valid;
         phs = resp_valid & resp_ready;
      end
   end

   bit seen;

   initial begin
      for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(12'(a));
      for (int i = 0; i < 16; i++) dead[i] = 1'b0;

      reset = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
      chk("rst_strobes", 32'(bank_read | bank_write), 32'd0);
      chk("rst_bank_addr", 32'(bank_addr), 32'd0);
      chk("rst_bank_wdata", 32'(bank_wdata), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;

      do_req(1'b1, 12'h123, 8'hA5, 1'b1);
      do_req(1'b0, 12'h123, 8'h00, 1'b1);

      for (int i = 0; i < 16; i++) do_req(1'b1, 12'(i), 8'(8'h10 + i), 1'b1);
      for (int i = 0; i < 16; i++) do_req(1'b0, 12'(i), 8'h00, 1'b1);

      do_req(1'b1, 12'hFFF, 8'h3C, 1'b1);
      do_req(1'b0, 12'hFFF, 8'h00, 1'b1);
      do_req(1'b0, 12'h000, 8'h00, 1'b1);
      drain();

      rdy_force = 1'b0;
      fork
         begin
            do_req(1'b0, 12'h123, 8'h00, 1'b1);
            do_req(1'b1, 12'h456, 8'h77, 1'b1);
         end
         begin
            seen = 1'b0;
            for (int n = 0; n < 100 && !seen; n++) begin
               @(negedge clock);
               seen = resp_valid;
            end
            chk("bp_resp_seen", 32'(seen), 32'd1);
            repeat (5) @(posedge clock);
            #1;
            rdy_force = 1'b1;
         end
      join
      drain();

      dead[7] = 1'b1;
      do_req(1'b0, 12'h007, 8'h00, 1'b1);
      do_req(1'b0, 12'h008, 8'h00, 1'b1);
      drain();
      dead[7] = 1'b0;

      do_req(1'b0, 12'h045, 8'h00, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("midrst_strobes", 32'(bank_read | bank_write), 32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_bank_addr", 32'(bank_addr), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      chk("midrst_no_stale", 32'(rq.size() + iq.size()), 32'd0);

      rand_rdy = 1'b1;
      for (int n = 0; n < 150; n++)
         do_req(1'($urandom_range(0, 1)), 12'($urandom_range(0, 255)), 8'($urandom), 1'b1);
      rand_rdy = 1'b0;
      rdy_force = 1'b1;
      drain();
      repeat (5) @(posedge clock);

      chk("resp_queue_empty", 32'(rq.size()), 32'd0);
      chk("issue_queue_empty", 32'(iq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/smem_initiator.md
Name: smem_initiator

Overview:
- Requester side of the shared-memory bank interface: takes one load/store at a time from a core and turns it into a single-cycle read/write strobe to one of 16 banks.
- Waits for that bank's `finish`, captures its `data_out`, and returns a response to the core.
- Sits between a core's load/store path and the 16 bank instances. Owns address-to-bank mapping and timeout detection.

Parameters:
- NBANKS, 16, number of banks; fixed at 16, 4-bit bank select.
- BANK_AW, 8, in-bank address width (256 entries per bank).
- DW, 8, data width.
- TIMEOUT, 15, WAIT cycles without `finish` before an error response; range 1..255.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE; request accepted on `req_valid & req_ready`.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  12  flat shared address.
- req_wdata  in  8  store data.
- resp_valid  out  1  response valid, held until `resp_ready`.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  8  load data; 0 for stores and errors.
- resp_err  out  1  1 = bank did not finish within TIMEOUT.
- bank_read  out  16  one-hot read strobe, bit i goes to bank i `read`.
- bank_write  out  16  one-hot write strobe, bit i goes to bank i `write`.
- bank_addr  out  8  shared `addr_in` to all banks.
- bank_wdata  out  8  shared `data_in` to all banks.
- bank_rdata  in  128  bank i `data_out` on bits [8i+7:8i].
- bank_finish  in  16  bank i `finish` on bit i.

Behaviour:
- Reset (`reset == 0` at a clock edge):
  - state = IDLE; `bank_read`, `bank_write`, `resp_valid`, `resp_err` = 0.
  - `resp_rdata`, `bank_addr`, `bank_wdata` = 0; timeout counter = 0.
  - Reset mid-operation abandons the transaction: no response, strobes low from the next edge.
- Address map is interleaved: bank = `req_addr[3:0]`, row = `req_addr[11:4]`. Consecutive addresses hit consecutive banks.
- Bank contract (responder side):
  - `data_out` and `finish` are registered.
  - A strobe high during cycle N gives `finish = 1` and valid `data_out` during cycle N+1.
  - The strobe must be exactly one cycle wide; a held strobe would re-trigger.
- State machine:
  - IDLE: `req_ready = 1`. On accept, latch `sel` (bank), row, wdata, write flag → ISSUE.
  - ISSUE, one cycle:
    - `bank_read[sel] = !write`, `bank_write[sel] = write`; all other bits 0.
    - `bank_addr` = row, `bank_wdata` = wdata; counter cleared → WAIT.
  - WAIT: strobes 0; `bank_addr` and `bank_wdata` hold their values.
    - If `bank_finish[sel]`: capture `bank_rdata[sel]` (loads) or 0 (stores) into `resp_rdata`; `resp_err = 0` → RESP.
    - Else increment the counter. When the counter reaches TIMEOUT: `resp_rdata = 0`, `resp_err = 1` → RESP.
    - `finish` from other banks is ignored.
  - RESP: `resp_valid = 1`; outputs stable. On `resp_ready` → IDLE, with `resp_valid` low the next cycle.
- Latency:
  - Accept edge E. ISSUE is cycle E+1, finish is seen in cycle E+2, `resp_valid` rises in cycle E+3.
  - Minimum request-to-request spacing is 4 cycles when `resp_ready` is tied high.
- Boundaries:
  - `resp_ready` high while `resp_valid` is low has no effect.
  - `req_valid` outside IDLE is ignored; the core holds the request.
  - Addresses 0x000 and 0xFFF map to bank 0 row 0 and bank 15 row 255.
  - No more than one strobe bit is ever high.
  - A late `finish` after timeout is ignored; the next transaction starts from ISSUE with a cleared counter.

Decomposition:
- Shared package `smem_pkg`: NBANKS, BANK_AW, DW, bank-select/row field positions, state encoding (IDLE/ISSUE/WAIT/RESP).
- Optional sub-module `smem_addr_map`: combinational split of `req_addr` into `sel` and row plus one-hot decode; reused by any future multi-requester arbiter.

Test Plan:
- Write then read, with 16 bank models attached:
  - Store 0xA5 to addr 0x123 → `bank_write[3]` pulses for exactly 1 cycle with `bank_addr = 0x12`, `bank_wdata = 0xA5`; `resp_valid` at E+3, `resp_rdata = 0`, `resp_err = 0`.
  - Load 0x123 → `bank_read[3]` pulses once; `resp_rdata = 0xA5`.
- Interleave: store values 0x10..0x1F to addrs 0x000..0x00F, then load them back → each bank i is written at row 0; loads return 0x10+i.
- Backpressure: hold `resp_ready = 0` for 5 cycles after `resp_valid` → `resp_valid`/`resp_rdata` stay stable, `req_ready` stays 0, and a pending `req_valid` is not accepted until 1 cycle after `resp_ready`.
- Timeout: bank 7 model never asserts `finish`; load 0x007 with TIMEOUT = 15 → `resp_valid` with `resp_err = 1`, `resp_rdata = 0`. A following load to 0x008 completes normally.
- Reset mid-op: assert `reset = 0` in the WAIT cycle → next edge shows `bank_*` strobes 0, `resp_valid` 0, `req_ready` 1 after release; no stale response.
- Boundary: store/load at 0xFFF → `bank_write[15]`/`bank_read[15]` with `bank_addr = 0xFF`; data round-trips.
